inst_rom_loader: RTL

Instruction-memory responder for the OpenMIPS fetch port: it answers the core's instruction fetches with the instruction word stored at the requested address. It also contains a byte-stream loader FSM that fills the memory at run time, holding the core in reset while it loads. It sits outside the `openmips` top in the SoC wrapper, beside the core:
- core fetch outputs (`rom_ce_o`, `rom_addr_o`) drive this block's fetch inputs;
- this block's `rom_data_o` drives the core's `rom_data_i`;
- this block's `cpu_rst_o` drives the core's `rst`.

---
 rtl/inst_rom_loader_if.sv | 30 +++
 rtl/inst_rom_loader.sv | 113 +++++++++++
 2 files changed

// File: rtl/inst_rom_loader_if.sv
// Fetch port and byte-stream loader bundle for inst_rom_loader.
// master: the core/loader side driving fetches and bytes; slave: the ROM/loader block.
interface inst_rom_loader_if #(
  parameter int unsigned ADDR_WIDTH = 10
);
  // Fetch port
  logic                  rom_ce_i;
  logic [31:0]           rom_addr_i;
  logic [31:0]           rom_data_o;
  // Loader stream
  logic                  ld_start_i;
  logic                  ld_valid_i;
  logic [7:0]            ld_data_i;
  logic                  ld_last_i;
  logic                  ld_ready_o;
  // Status
  logic                  cpu_rst_o;
  logic [ADDR_WIDTH:0]   words_o;
  logic                  err_o;

  modport master (
    output rom_ce_i, rom_addr_i, ld_start_i, ld_valid_i, ld_data_i, ld_last_i,
    input  rom_data_o, ld_ready_o, cpu_rst_o, words_o, err_o
  );

  modport slave (
    input  rom_ce_i, rom_addr_i, ld_start_i, ld_valid_i, ld_data_i, ld_last_i,
    output rom_data_o, ld_ready_o, cpu_rst_o, words_o, err_o
  );
endinterface

// File: rtl/inst_rom_loader.sv
// Instruction memory for the OpenMIPS fetch port, filled at run time by a byte-stream
// loader that holds the core in reset until the image has been received.
module inst_rom_loader #(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input logic               clk,
  input logic               rst,
  inst_rom_loader_if.slave  bus
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {StIdle, StLoad, StRun} state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] ptr_q;
  logic [ADDR_WIDTH:0]   words_q;
  logic [1:0]            byte_cnt_q;
  logic [31:0]           asm_q;
  logic                  err_q;
  logic                  ready_q;
  logic                  cpu_rst_q;

  logic [31:0]           mem [Depth];

  logic                  xfer;
  logic                  take;
  logic                  full;
  logic                  word_done;
  logic                  wr_en;
  logic [31:0]           merged;
  logic [ADDR_WIDTH-1:0] rd_idx;
  logic                  unused_addr;

  // A byte offered while start is high is consumed but dropped: the session restarts.
  assign xfer      = bus.ld_valid_i & ready_q;
  assign take      = xfer & ~bus.ld_start_i;
  // words_q == Depth is the only value with the top bit set.
  assign full      = words_q[ADDR_WIDTH];
  assign word_done = take & ((byte_cnt_q == 2'd3) | bus.ld_last_i);
  assign wr_en     = word_done & ~full;

  // Insert the incoming byte big-endian into the partially assembled word.
  always_comb begin
    merged = asm_q;
    unique case (byte_cnt_q)
      2'd0: merged[31:24] = bus.ld_data_i;
      2'd1: merged[23:16] = bus.ld_data_i;
      2'd2: merged[15:8]  = bus.ld_data_i;
      2'd3: merged[7:0]   = bus.ld_data_i;
    endcase
  end

  // Memory write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[ptr_q] <= merged;
    end
  end

  // Loader FSM with registered handshake/status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      ready_q    <= 1'b0;
      cpu_rst_q  <= 1'b1;
      ptr_q      <= '0;
      words_q    <= '0;
      byte_cnt_q <= '0;
      asm_q      <= '0;
      err_q      <= 1'b0;
    end else if (bus.ld_start_i) begin
      state_q    <= StLoad;
      ready_q    <= 1'b1;
      cpu_rst_q  <= 1'b1;
      ptr_q      <= '0;
      words_q    <= '0;
      byte_cnt_q <= '0;
      asm_q      <= '0;
      err_q      <= 1'b0;
    end else if (take) begin
      byte_cnt_q <= byte_cnt_q + 2'd1;
      asm_q      <= merged;
      if (full) begin
        err_q <= 1'b1;
      end
      if (word_done) begin
        byte_cnt_q <= '0;
        asm_q      <= '0;
      end
      if (wr_en) begin
        ptr_q   <= ptr_q + ADDR_WIDTH'(1);
        words_q <= words_q + (ADDR_WIDTH + 1)'(1);
      end
      if (bus.ld_last_i) begin
        state_q   <= StRun;
        ready_q   <= 1'b0;
        cpu_rst_q <= 1'b0;
      end
    end
  end

  // Fetch path: word index from the byte address, aliasing modulo the depth.
  assign rd_idx         = bus.rom_addr_i[ADDR_WIDTH+1:2];
  assign bus.rom_data_o = (bus.rom_ce_i && (state_q == StRun)) ? mem[rd_idx] : 32'h0;
  assign unused_addr    = ^{bus.rom_addr_i[31:ADDR_WIDTH+2], bus.rom_addr_i[1:0]};

  assign bus.ld_ready_o = ready_q;
  assign bus.cpu_rst_o  = cpu_rst_q;
  assign bus.words_o    = words_q;
  assign bus.err_o      = err_q;

endmodule
